// File: rtl/axi_burst_writer_pkg.sv
// Shared types and AXI3 constants for the multi-channel DDR capture writer.
// Holds the writer FSM encoding and the beat-size helper used to drive AWSIZE.
package pdh_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARB,
        ST_BURST,
        ST_RESP
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    function automatic logic [2:0] axi_size(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/axi_burst_writer_if.sv
// AXI3 write-only master bundle (AW, W, B) between the capture writer and the HP port.
// Master drives addresses, data and bready; slave drives the readies, bvalid and bresp.
interface axi_burst_writer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [3:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic                bvalid;
    logic                bready;
    logic [1:0]          bresp;

    modport master (
        output awaddr, awvalid, awlen, awsize, awburst,
        output wdata, wstrb, wlast, wvalid, bready,
        input  awready, wready, bvalid, bresp
    );

    modport slave (
        input  awaddr, awvalid, awlen, awsize, awburst,
        input  wdata, wstrb, wlast, wvalid, bready,
        output awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/axi_burst_writer_rr.sv
// Round-robin arbiter: combinational one-hot grant searched from the channel after the last grant.
// The last-grant pointer moves only when advance is pulsed with a valid grant.
module rr_arbiter #(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic              gnt_vld,
    output logic [NUM_CH-1:0] gnt,
    output logic [IDX_W-1:0]  gnt_idx
);

    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] cand;
    int               pos;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        pos     = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            pos = int'(last) + i;
            if (pos >= NUM_CH) pos = pos - NUM_CH;
            cand = IDX_W'(pos);
            if (!gnt_vld && req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt = gnt_vld ? (NUM_CH'(1) << gnt_idx) : '0;
    end

    // Reset so that channel 0 wins the first arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= IDX_W'(NUM_CH - 1);
        end else if (advance && gnt_vld) begin
            last <= gnt_idx;
        end
    end

endmodule

// File: rtl/axi_burst_writer.sv
// Arbitrates NUM_CH capture FIFOs and writes fixed-length AXI3 INCR bursts into per-channel DDR regions.
// Two idle cycles between bursts; AW and W run independently and the FSM waits for both plus B.
module axi_burst_writer
    import pdh_dma_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int DATA_W       = 64,
    parameter int BURST_LEN    = 16,
    parameter int REGION_BYTES = 1048576,
    parameter int ADDR_W       = 32
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     enable_i,
    input  logic                     ring_mode_i,
    input  logic [NUM_CH*ADDR_W-1:0] base_addr_i,
    input  logic [NUM_CH-1:0]        ch_avail_i,
    input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
    output logic [NUM_CH-1:0]        ch_pop_o,
    axi_burst_writer_if.master       m_axi,
    output logic                     busy_o,
    output logic [NUM_CH-1:0]        done_o,
    output logic                     err_o,
    output logic [NUM_CH*16-1:0]     wrap_cnt_o,
    output logic [NUM_CH*32-1:0]     wr_ptr_o
);

    localparam int BURST_BYTES = BURST_LEN * (DATA_W / 8);
    localparam int IDX_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    gnt_idx;
    logic [NUM_CH-1:0]   gnt_oh;
    logic [ADDR_W-1:0]   awaddr_q;
    logic                aw_done, w_done;
    logic [BEAT_W-1:0]   beat_cnt;
    logic                en_q, clr_pend, ring_q, err_q;
    logic [NUM_CH-1:0]   done_q, misalign, elig;
    logic [31:0]         wr_ptr   [NUM_CH];
    logic [15:0]         wrap_cnt [NUM_CH];
    logic [DATA_W-1:0]   ch_data  [NUM_CH];
    logic [ADDR_W-1:0]   base     [NUM_CH];

    logic                arb_vld;
    logic [NUM_CH-1:0]   arb_oh;
    logic [IDX_W-1:0]    arb_idx;

    logic en_rise, clear_now, aw_hs, w_hs, b_hs, burst_end;
    logic [31:0] ptr_nxt;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_data[i]  = ch_data_i[i*DATA_W +: DATA_W];
        assign base[i]     = base_addr_i[i*ADDR_W +: ADDR_W];
        // Burst-aligned bases keep every burst inside one 4 KB page.
        assign misalign[i] = |(base[i] & ADDR_W'(BURST_BYTES - 1));
        assign elig[i]     = ch_avail_i[i] & ~done_q[i] & ~misalign[i];
        assign wr_ptr_o[i*32 +: 32]   = wr_ptr[i];
        assign wrap_cnt_o[i*16 +: 16] = wrap_cnt[i];
    end

    rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_arb (
        .clk     (aclk),
        .rst_n   (aresetn),
        .req     (elig),
        .advance (state == ST_ARB),
        .gnt_vld (arb_vld),
        .gnt     (arb_oh),
        .gnt_idx (arb_idx)
    );

    assign en_rise   = enable_i & ~en_q;
    assign clear_now = (state == ST_IDLE) & (en_rise | clr_pend);
    assign aw_hs     = m_axi.awvalid & m_axi.awready;
    assign w_hs      = m_axi.wvalid & m_axi.wready;
    assign b_hs      = m_axi.bvalid & m_axi.bready;
    assign burst_end = (aw_done | aw_hs) & (w_done | (w_hs & m_axi.wlast));
    assign ptr_nxt   = wr_ptr[gnt_idx] + 32'(BURST_BYTES);

    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awvalid = (state == ST_BURST) & ~aw_done;
    assign m_axi.awlen   = 4'(BURST_LEN - 1);
    assign m_axi.awsize  = axi_size(DATA_W);
    assign m_axi.awburst = BURST_INCR;
    assign m_axi.wdata   = ch_data[gnt_idx];
    assign m_axi.wstrb   = '1;
    assign m_axi.wvalid  = (state == ST_BURST) & ~w_done;
    assign m_axi.wlast   = m_axi.wvalid & (beat_cnt == BEAT_W'(BURST_LEN - 1));
    assign m_axi.bready  = (state == ST_RESP);

    assign ch_pop_o = gnt_oh & {NUM_CH{w_hs}};
    assign busy_o   = (state != ST_IDLE);
    assign done_o   = done_q;
    assign err_o    = err_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (!clear_now && enable_i && (|elig)) state_nxt = ST_ARB;
            ST_ARB:   state_nxt = arb_vld ? ST_BURST : ST_IDLE;
            ST_BURST: if (burst_end) state_nxt = ST_RESP;
            ST_RESP:  if (b_hs) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            en_q     <= 1'b0;
            clr_pend <= 1'b0;
            ring_q   <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= '0;
            gnt_idx  <= '0;
            gnt_oh   <= '0;
            awaddr_q <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            beat_cnt <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr[i]   <= '0;
                wrap_cnt[i] <= '0;
            end
        end else begin
            en_q <= enable_i;
            // A new session requested mid-burst is applied once the FSM is back in IDLE.
            if (clear_now)    clr_pend <= 1'b0;
            else if (en_rise) clr_pend <= 1'b1;

            if (state == ST_ARB) begin
                gnt_idx  <= arb_idx;
                gnt_oh   <= arb_oh;
                awaddr_q <= base[arb_idx] + ADDR_W'(wr_ptr[arb_idx]);
                aw_done  <= 1'b0;
                w_done   <= 1'b0;
                beat_cnt <= '0;
            end else begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs) begin
                    beat_cnt <= beat_cnt + BEAT_W'(1);
                    if (m_axi.wlast) w_done <= 1'b1;
                end
            end

            if (clear_now) begin
                ring_q <= ring_mode_i;
                err_q  <= |misalign;
                done_q <= '0;
                for (int i = 0; i < NUM_CH; i++) begin
                    wr_ptr[i]   <= '0;
                    wrap_cnt[i] <= '0;
                end
            end else if (b_hs) begin
                if (m_axi.bresp != RESP_OKAY) err_q <= 1'b1;
                if (ptr_nxt == 32'(REGION_BYTES)) begin
                    if (ring_q) begin
                        wr_ptr[gnt_idx] <= '0;
                        if (wrap_cnt[gnt_idx] != 16'hFFFF)
                            wrap_cnt[gnt_idx] <= wrap_cnt[gnt_idx] + 16'd1;
                    end else begin
                        wr_ptr[gnt_idx] <= ptr_nxt;
                        done_q[gnt_idx] <= 1'b1;
                    end
                end else begin
                    wr_ptr[gnt_idx] <= ptr_nxt;
                end
            end
        end
    end

    // The source must keep its burst's worth of words until the first beat is taken.
    a_avail_held: assert property (@(posedge aclk) disable iff (!aresetn)
        (state == ST_BURST && beat_cnt == '0 && !w_done) |-> ch_avail_i[gnt_idx]);

endmodule

// File: tb/tb_axi_burst_writer.sv
// Scoreboard bench for axi_burst_writer: FIFO model per channel, AXI slave responder, expected AW/W queues.
module tb_axi_burst_writer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable, ring;
    logic [63:0]  base_addr;
    logic [1:0]   ch_avail;
    logic [127:0] ch_data;
    logic [1:0]   ch_pop;
    logic         busy, err;
    logic [1:0]   done;
    logic [31:0]  wrap_cnt;
    logic [63:0]  wr_ptr;

    always #5 clk = ~clk;

    axi_burst_writer_if #(.ADDR_W(32), .DATA_W(64)) axi ();

    axi_burst_writer #(
        .NUM_CH(2), .DATA_W(64), .BURST_LEN(16), .REGION_BYTES(256), .ADDR_W(32)
    ) dut (
        .aclk(clk), .aresetn(rst_n), .enable_i(enable), .ring_mode_i(ring),
        .base_addr_i(base_addr), .ch_avail_i(ch_avail), .ch_data_i(ch_data),
        .ch_pop_o(ch_pop), .m_axi(axi), .busy_o(busy), .done_o(done), .err_o(err),
        .wrap_cnt_o(wrap_cnt), .wr_ptr_o(wr_ptr)
    );

    int n_chk = 0, n_pass = 0;
    int load[2], popped[2], exp_seq[2];
    logic [31:0] exp_aw[$];
    logic [63:0] exp_wd[$];
    int          exp_wc[$];
    int aw_cnt = 0, wl_cnt = 0, b_cnt = 0, w_cnt = 0, beat_in = 0, w_first = 0;
    int err_at = -1;
    logic bp_en = 1'b0;

    function automatic logic [63:0] word(input int c, input int s);
        return {8'(c), 24'hA5C3E1, 32'(s)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Channel FIFO model: words are numbered by pop count; avail means a full burst is queued.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            ch_data[c*64 +: 64] = word(c, popped[c]);
            ch_avail[c]         = (load[c] - popped[c]) >= 16;
        end
    end

    always @(posedge clk) begin
        for (int c = 0; c < 2; c++)
            if (ch_pop[c]) popped[c] <= popped[c] + 1;
    end

    // AXI slave + monitor: drive readies/B at negedge, then check handshakes due at the next posedge.
    initial begin
        logic b_pend, aw_now, w_now;
        logic [31:0] ea;
        logic [63:0] wd;
        int wc;
        b_pend = 1'b0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        forever begin
            @(negedge clk);
            if (b_pend) begin
                axi.bvalid = 1'b0;
                b_cnt++;
            end
            if (bp_en) begin
                axi.awready = (aw_cnt % 2 == 0) ? (wl_cnt > aw_cnt) : ($urandom_range(0, 2) == 0);
                axi.wready  = ($urandom_range(0, 3) != 0);
            end else begin
                axi.awready = 1'b1;
                axi.wready  = 1'b1;
            end
            if (!axi.bvalid && aw_cnt > b_cnt && wl_cnt > b_cnt) begin
                axi.bvalid = 1'b1;
                axi.bresp  = (b_cnt == err_at) ? 2'b10 : 2'b00;
            end
            #1;
            b_pend = axi.bvalid && axi.bready;
            aw_now = axi.awvalid && axi.awready;
            w_now  = axi.wvalid && axi.wready;
            if (w_now && axi.wlast && !aw_now && aw_cnt == wl_cnt) w_first++;
            if (aw_now) begin
                chk("aw_expected", 64'(exp_aw.size() != 0), 1);
                if (exp_aw.size() != 0) begin
                    ea = exp_aw.pop_front();
                    chk("awaddr", axi.awaddr, ea);
                end
                chk("awlen", axi.awlen, 15);
                chk("awsize", axi.awsize, 3);
                aw_cnt++;
            end
            if (w_now) begin
                chk("w_expected", 64'(exp_wd.size() != 0), 1);
                if (exp_wd.size() != 0) begin
                    wd = exp_wd.pop_front();
                    wc = exp_wc.pop_front();
                    chk("wdata", axi.wdata, wd);
                    chk("pop", ch_pop, 2'b01 << wc);
                end
                chk("wlast", axi.wlast, beat_in == 15);
                w_cnt++;
                if (axi.wlast) begin
                    wl_cnt++;
                    beat_in = 0;
                end else begin
                    beat_in++;
                end
            end else if (ch_pop != 2'b00) begin
                chk("pop_idle", ch_pop, 0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #7;
        end
    endtask

    task automatic push_burst(input int c, input logic [31:0] addr);
        exp_aw.push_back(addr);
        for (int i = 0; i < 16; i++) begin
            exp_wd.push_back(word(c, exp_seq[c]));
            exp_wc.push_back(c);
            exp_seq[c]++;
        end
    endtask

    task automatic start_session(input logic ring_v);
        enable = 1'b0;
        tick(2);
        ring   = ring_v;
        enable = 1'b1;
    endtask

    task automatic wait_b(input string tag, input int target, input int budget);
        int k = 0;
        while (b_cnt < target && k < budget) begin
            tick(1);
            k++;
        end
        chk(tag, b_cnt, target);
    endtask

    task automatic quiet(input string tag);
        int a = aw_cnt;
        tick(40);
        chk(tag, aw_cnt, a);
        chk({tag, "_queue"}, exp_aw.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b0, p0, p1, w0, k;
        enable    = 1'b0;
        ring      = 1'b0;
        base_addr = {32'h1008_0000, 32'h1000_0000};
        load[0] = 0; load[1] = 0;
        exp_seq[0] = 0; exp_seq[1] = 0;
        repeat (3) @(posedge clk);
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_wrap", wrap_cnt, 0);
        chk("rst_ptr", wr_ptr, 0);
        chk("rst_awvalid", axi.awvalid, 0);
        chk("rst_wvalid", axi.wvalid, 0);
        chk("rst_bready", axi.bready, 0);
        chk("rst_pop", ch_pop, 0);
        chk("rst_awlen", axi.awlen, 15);
        chk("rst_awsize", axi.awsize, 3);
        chk("rst_awburst", axi.awburst, 1);
        chk("rst_wstrb", axi.wstrb, 8'hFF);
        rst_n = 1'b1;
        tick(2);

        // Two channels, one-shot: grants alternate starting at ch0.
        load[0] += 32; load[1] += 32;
        push_burst(0, 32'h1000_0000);
        push_burst(1, 32'h1008_0000);
        push_burst(0, 32'h1000_0080);
        push_burst(1, 32'h1008_0080);
        b0 = b_cnt;
        start_session(1'b0);
        wait_b("t2_b1", b0 + 1, 300);
        chk("t2_ptr0_a", wr_ptr[31:0], 32'h80);
        wait_b("t2_b2", b0 + 2, 300);
        chk("t2_ptr1_a", wr_ptr[63:32], 32'h80);
        wait_b("t2_b4", b0 + 4, 300);
        quiet("t2_no_extra_aw");
        chk("t2_done", done, 2'b11);
        chk("t2_ptr0", wr_ptr[31:0], 32'h100);
        chk("t2_ptr1", wr_ptr[63:32], 32'h100);
        chk("t2_busy", busy, 0);

        // Single channel, one-shot, more data than the region holds.
        load[0] += 48;
        push_burst(0, 32'h1000_0000);
        push_burst(0, 32'h1000_0080);
        b0 = b_cnt;
        start_session(1'b0);
        wait_b("t1_b2", b0 + 2, 300);
        quiet("t1_no_third_aw");
        chk("t1_done", done, 2'b01);
        chk("t1_ptr0", wr_ptr[31:0], 32'h100);
        chk("t1_ptr1", wr_ptr[63:32], 0);

        // Ring mode, five bursts on ch0.
        load[0] += 64;
        push_burst(0, 32'h1000_0000);
        push_burst(0, 32'h1000_0080);
        push_burst(0, 32'h1000_0000);
        push_burst(0, 32'h1000_0080);
        push_burst(0, 32'h1000_0000);
        b0 = b_cnt;
        start_session(1'b1);
        wait_b("t3_b5", b0 + 5, 600);
        quiet("t3_no_extra_aw");
        chk("t3_wrap0", wrap_cnt[15:0], 2);
        chk("t3_wrap1", wrap_cnt[31:16], 0);
        chk("t3_ptr0", wr_ptr[31:0], 32'h80);
        chk("t3_done", done, 0);

        // Backpressure; even bursts hold AW until their W side has finished.
        load[0] += 32; load[1] += 32;
        push_burst(1, 32'h1008_0000);
        push_burst(0, 32'h1000_0000);
        push_burst(1, 32'h1008_0080);
        push_burst(0, 32'h1000_0080);
        p0 = popped[0]; p1 = popped[1];
        b0 = b_cnt;
        w0 = w_first;
        bp_en = 1'b1;
        start_session(1'b0);
        wait_b("t4_b4", b0 + 4, 1500);
        bp_en = 1'b0;
        quiet("t4_no_extra_aw");
        chk("t4_w_before_aw", 64'((w_first - w0) >= 2), 1);
        chk("t4_pops0", popped[0] - p0, 32);
        chk("t4_pops1", popped[1] - p1, 32);
        chk("t4_done", done, 2'b11);

        // Error response on the second burst: sticky, capture continues.
        load[0] += 64;
        push_burst(0, 32'h1000_0000);
        push_burst(0, 32'h1000_0080);
        push_burst(0, 32'h1000_0000);
        push_burst(0, 32'h1000_0080);
        b0 = b_cnt;
        err_at = b0 + 1;
        start_session(1'b1);
        wait_b("t5_b1", b0 + 1, 300);
        chk("t5_err_before", err, 0);
        wait_b("t5_b2", b0 + 2, 300);
        chk("t5_err_set", err, 1);
        wait_b("t5_b4", b0 + 4, 300);
        chk("t5_err_sticky", err, 1);
        chk("t5_wrap0", wrap_cnt[15:0], 2);
        quiet("t5_no_extra_aw");
        err_at = -1;
        enable = 1'b0;
        tick(3);
        chk("t5_err_disabled", err, 1);
        enable = 1'b1;
        tick(3);
        chk("t5_err_cleared", err, 0);

        // enable_i drops mid-burst: that burst completes, nothing further starts.
        load[0] += 32;
        push_burst(0, 32'h1000_0000);
        b0 = b_cnt;
        w0 = w_cnt;
        start_session(1'b0);
        k = 0;
        while (w_cnt < w0 + 5 && k < 200) begin
            tick(1);
            k++;
        end
        chk("t6_beat5", 64'(w_cnt >= w0 + 5), 1);
        enable = 1'b0;
        wait_b("t6_b1", b0 + 1, 300);
        quiet("t6_no_new_aw");
        chk("t6_ptr0", wr_ptr[31:0], 32'h80);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);

        // Misaligned ch1 base: error at session start, ch1 never granted.
        base_addr = {32'h1008_0008, 32'h1000_0000};
        load[0] += 16; load[1] += 32;
        push_burst(0, 32'h1000_0000);
        push_burst(0, 32'h1000_0080);
        p1 = popped[1];
        b0 = b_cnt;
        start_session(1'b0);
        tick(3);
        chk("t6m_err_early", err, 1);
        wait_b("t6m_b2", b0 + 2, 400);
        quiet("t6m_no_ch1_aw");
        chk("t6m_err", err, 1);
        chk("t6m_done", done, 2'b01);
        chk("t6m_ptr1", wr_ptr[63:32], 0);
        chk("t6m_ch1_pops", popped[1] - p1, 0);
        enable = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axi_burst_writer.md
Name: axi_burst_writer

Overview:
Parametrised multi-channel successor to the single-stream DDR capture path. It arbitrates round-robin among NUM_CH capture channels, each fronted by its own FIFO. For each granted channel it issues fixed-length AXI3 INCR write bursts into that channel's DDR region, in one-shot or ring (circular) mode. It sits in the fclk0 domain between the per-channel clock-crossing FIFOs and the HP0 slave port, and reports per-channel progress and status to the PS control path.

Parameters:
NUM_CH, 2, number of capture channels (1..8)
DATA_W, 64, AXI data width; 32 or 64 only
BURST_LEN, 16, beats per burst (1..16, AXI3 limit)
REGION_BYTES, 1048576, bytes per channel region; power of two and a multiple of burst bytes
ADDR_W, 32, AXI address width

Ports:
aclk  in  1  fclk0 clock
aresetn  in  1  asynchronous active-low reset
enable_i  in  1  capture enable; its rising edge starts a new capture session
ring_mode_i  in  1  0 = one-shot, 1 = ring; sampled on enable_i rising edge
base_addr_i  in  NUM_CH*ADDR_W  per-channel region base address
ch_avail_i  in  NUM_CH  channel FIFO holds at least BURST_LEN words
ch_data_i  in  NUM_CH*DATA_W  channel FIFO head word (first-word fall-through)
ch_pop_o  out  NUM_CH  pop strobe, one per accepted W beat
m_axi_awaddr/awvalid/awready/awlen/awsize/awburst  AXI3 AW channel (out/out/in/out/out/out)
m_axi_wdata/wstrb/wlast/wvalid/wready  AXI3 W channel (out/out/out/out/in)
m_axi_bvalid/bready/bresp  AXI3 B channel (in/out/in)
busy_o  out  1  a burst is in flight
done_o  out  NUM_CH  one-shot region for that channel is full
err_o  out  1  sticky: BRESP not OKAY, or misaligned base address
wrap_cnt_o  out  NUM_CH*16  ring-mode wrap count per channel
wr_ptr_o  out  NUM_CH*32  byte offset of next burst per channel

Behaviour:
- Reset values:
  - All valid/ready/pop outputs 0.
  - busy_o, done_o, err_o, wrap_cnt_o, wr_ptr_o all 0.
  - awlen, awsize, awburst, wstrb are constants: awlen = BURST_LEN-1; awsize = log2(DATA_W/8); awburst = 2'b01 (INCR); wstrb all ones.
- FSM states: IDLE, ARB, BURST, RESP.
- IDLE → ARB when enable_i=1 and at least one channel is eligible.
  - Eligible = ch_avail_i=1, done=0, and base address aligned.
- ARB (1 cycle):
  - Round-robin grant, starting at the channel after the last grant.
  - Latch awaddr = base + wr_ptr.
  - Go to BURST.
- BURST:
  - awvalid and wvalid both rise the same cycle after ARB. They are independent; neither waits on the other's handshake.
  - awvalid holds until awready. wvalid holds continuously, never depending on wready.
  - wdata = granted channel's ch_data_i. ch_pop_o[g] = wvalid & wready.
  - wlast is asserted on beat BURST_LEN-1.
  - Leave for RESP once both the AW handshake and the wlast handshake are done, in either order.
- RESP:
  - bready = 1.
  - On bvalid: if bresp != 0, set err_o. wr_ptr += BURST_LEN*DATA_W/8.
  - If wr_ptr reaches REGION_BYTES:
    - one-shot: set done[g] and hold wr_ptr at REGION_BYTES;
    - ring: wr_ptr = 0, wrap_cnt += 1 (saturating at 16'hFFFF).
  - Then go to IDLE.
- busy_o = 1 in ARB, BURST, RESP.
- Minimum gap between bursts: 2 cycles (IDLE, ARB).
- Session start (enable_i rising edge, registered edge detect):
  - Clears wr_ptr, wrap_cnt, done, err; latches ring_mode.
  - Any channel whose base is not aligned to burst bytes sets err_o and is never granted this session.
- enable_i falling mid-burst: the current burst and its B response complete normally (no AXI abort), then the FSM returns to IDLE.
- enable_i rising while busy: clear is deferred until the FSM reaches IDLE.
- ch_avail_i dropping during a granted burst is a protocol violation by the source. It is flagged by a simulation assertion only.
- Asynchronous reset mid-burst: immediate return to reset values. Keeping the interconnect reset in the same domain is an integration requirement.
- All 4 KB crossings are avoided by construction: alignment is checked, and burst bytes ≤ 128.

Decomposition:
- Package pdh_dma_pkg:
  - state enum;
  - AXI burst/resp constants (BURST_INCR, RESP_OKAY);
  - function clog2-based awsize derivation.
- One sub-module: rr_arbiter (parametrised NUM_CH, grant with last-grant pointer, one-hot output).

Test Plan:
1. NUM_CH=1, one-shot, REGION_BYTES=256, base 0x1000_0000, avail held high → exactly 2 bursts at 0x1000_0000 and 0x1000_0080, awlen=15, awsize=3; done_o=1; no third AW.
2. Two channels with bases 0x1000_0000 and 0x1008_0000, both avail → grants alternate ch0, ch1, ch0, ch1; wr_ptr_o for each channel advances by 0x80 per burst.
3. Ring mode, REGION_BYTES=256, 5 bursts on ch0 → addresses at offsets 0x00, 0x80, 0x00, 0x80, 0x00; wrap_cnt=2; done_o stays 0.
4. Random awready/wready backpressure, including W completing before AW → 16 beats per burst, wlast on beat 16 only, 16 pops per burst, data order preserved.
5. bresp=2'b10 on the second burst → err_o set and sticky; capture continues; err_o clears only on the next enable_i rising edge.
6. Drop enable_i at beat 5, plus a separate run with base 0x1000_0008 → burst 1 completes and no new AW is issued; in the misaligned run err_o=1 and that channel is never granted.
